// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-bus snooping UART transmitter, FIFO-buffered 8N1 serial output
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 174,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0100,
  parameter logic [31:0] CTRL_ADDR    = 32'h0000_0104,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemWrite,
  input  logic [31:0]                   DataAddr,
  input  logic [31:0]                   WriteData,
  output logic                          tx,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_req, clr_req, last, pop, push;
  logic          unused_wd;
  assign unused_wd  = &{1'b0, WriteData[31:8]};
  assign fifo_full  = fifo_count == (PW+1)'(FIFO_DEPTH);
  assign fifo_empty = fifo_count == '0;
  assign busy       = state != IDLE;
  // store decode and pop/push arbitration; a pop frees the slot a same-cycle push needs
  always_comb begin
    push_req = MemWrite && DataAddr == TX_ADDR;
    clr_req  = MemWrite && DataAddr == CTRL_ADDR && WriteData[0];
    last     = cnt == CW'(CLKS_PER_BIT - 1);
    pop      = !fifo_empty && (state == IDLE || (state == STOP && last));
    push     = push_req && (!fifo_full || pop);
  end
  // FIFO storage, not reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= WriteData[7:0];
  end
  // FIFO pointers, occupancy and sticky overflow (a drop beats a same-cycle clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
      overflow   <= (push_req && !push) ? 1'b1 : clr_req ? 1'b0 : overflow;
    end
  end
  // serial engine; tx is registered and set on the edge that enters each bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shift <= mem[rd_ptr];
          state <= START;
          cnt   <= '0;
          tx    <= 1'b0;
        end
        START: if (last) begin
          state <= DATA;
          idx   <= '0;
          cnt   <= '0;
          tx    <= shift[0];
        end else cnt <= cnt + CW'(1);
        DATA: if (last) begin
          cnt <= '0;
          if (idx == 3'd7) begin
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            idx   <= idx + 3'd1;
            shift <= shift >> 1;
            tx    <= shift[1];
          end
        end else cnt <= cnt + CW'(1);
        default: if (last) begin
          cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
            tx    <= 1'b0;
          end else state <= IDLE;
        end else cnt <= cnt + CW'(1);
      endcase
    end
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits directly downstream of the single-cycle RISC-V core on the data-memory store bus. Each cycle it watches the core's `MemWrite`, `ALUResult`/`DataAddr` and `WriteData`. A store to the TX data address pushes the low byte into a FIFO, and a serial engine drains the FIFO as 8N1 frames on `tx`. It runs on the same 20 MHz local clock as the core and gives a running program visible output on the FPGA board.

## Interface
- `CLKS_PER_BIT`, 174: clock cycles per UART bit (20 MHz / 115200, rounded); legal range ≥ 2.
- `TX_ADDR`, 32'h0000_0100: byte address of the TX data register.
- `CTRL_ADDR`, 32'h0000_0104: byte address of the control register.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥ 2.

- `clk`  in  1  core clock (20 MHz local clock).
- `reset`  in  1  synchronous, active-high reset.
- `MemWrite`  in  1  store strobe from core, valid for the whole cycle.
- `DataAddr`  in  32  store address (core ALU result).
- `WriteData`  in  32  store data; only [7:0] is used for TX.
- `tx`  out  1  serial output; idles high.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH entries.
- `fifo_empty`  out  1  FIFO holds 0 entries.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky; a TX store was dropped.
- `busy`  out  1  FSM not in IDLE.

## Operation
- **Push condition:** `MemWrite && DataAddr == TX_ADDR`, full 32-bit compare. `WriteData[7:0]` is written at the tail.
- **Full FIFO:**
  - If the FIFO is full and no pop occurs in the same cycle, the push is dropped, `overflow` is set, and the FIFO contents are unchanged.
  - If the FIFO is full and a pop occurs in the same cycle, the push is accepted and the count is unchanged.
- **Control register:** a store with `MemWrite && DataAddr == CTRL_ADDR && WriteData[0]` clears `overflow`. If the clear and an overflow event happen in the same cycle, the set wins.
- **Other stores:** stores to any other address are ignored. No read path; loads are not decoded.
- **FSM states:** IDLE, START, DATA, STOP. The bit counter is 0..CLKS_PER_BIT-1; the bit index is 0..7.
  - IDLE: `tx`=1. If the FIFO is non-empty: pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the last cycle: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Pop/push ordering:** a pop and a push in the same cycle with a non-empty FIFO leaves the count unchanged and preserves order.
- **Output sources:** `tx` is driven from a register (glitch-free). `busy` = state != IDLE.

## Timing
- **Reset values:** `tx`=1, `fifo_empty`=1, `fifo_full`=0, `fifo_count`=0, `overflow`=0, `busy`=0. State=IDLE, pointers=0.
- **Reset mid-frame:** the frame aborts, `tx` is high at the next edge, and the FIFO is discarded.
- **Push latency:** a store in cycle N is visible in `fifo_count`/`fifo_empty` at cycle N+1.
- **Start latency:** with an empty FIFO and an IDLE FSM, a store in cycle N pops at edge N+1. `tx` goes low in cycle N+2 and `busy`=1 from N+2.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- **Pointer wrap:** pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth. Full/empty are derived from `fifo_count`.
- **Flag updates:** `overflow` updates at the edge ending the offending cycle.

## Test plan
- **Single byte:** CLKS_PER_BIT=4, store 32'h0000_0155 to TX_ADDR. Expect `tx` low at +2 cycles for 4 cycles, then data bits 1,0,1,0,1,0,1,0, then high for 4 cycles. `busy` returns to 0 after 40 cycles.
- **Address filter:** stores to 0x0FC, 0x108 and 0x100 with `MemWrite`=0. Expect no push, `fifo_count`=0 and `tx` held at 1.
- **Back-to-back:** push 0x41, 0x42, 0x43 on consecutive cycles. Expect three contiguous 40-cycle frames with no idle cycle between them, and `fifo_count` sequence 1,1,2,... falling to 0.
- **Overflow:** FIFO_DEPTH=4, FSM held busy, push 6 bytes. Expect the first pops plus up to 4 held bytes accepted, `fifo_full`=1 and `overflow`=1 on the first drop. A store of 1 to CTRL_ADDR clears `overflow`, and the dropped bytes never appear on `tx`.
- **Push+pop when full:** push on the exact STOP→START pop cycle while full. Expect the push accepted and the count unchanged at 4.
- **Reset mid-frame:** assert `reset` during DATA bit 3. Expect `tx`=1 the next cycle, `fifo_count`=0, `busy`=0, and no resumed frame after reset is released.
